dht11_medidor: RTL
==================

Name: dht11_medidor

Overview:
Single-wire DHT11 reader, directly upstream of the TUSCA control unit. It takes the control unit's one-cycle measure request (medir_dht11) and runs the DHT11 start/response/40-bit protocol on an open-drain line. It returns a one-cycle pronto pulse with latched humidity/temperature bytes, or a one-cycle erro pulse. These pulses feed pronto_medida and erro_medida.

Parameters:
CLK_HZ, 50000000, system clock frequency; CICLOS_US = CLK_HZ/1000000 (must be ≥1)
T_START_US, 20000, host start-low hold time in µs
T_LIMIAR_US, 50, bit-high duration threshold; a duration > threshold decodes as 1
T_TIMEOUT_US, 200, maximum µs in any sensor-driven wait phase before error

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
medir  in  1  one-cycle measure request
dht_in  in  1  raw line level (async; pulled-up bus)
dht_oe  out  1  1 = drive line low; 0 = release (open-drain)
umidade_int  out  8  humidity integer byte
umidade_dec  out  8  humidity decimal byte
temperatura_int  out  8  temperature integer byte
temperatura_dec  out  8  temperature decimal byte
pronto  out  1  one-cycle pulse: valid frame latched
erro  out  1  one-cycle pulse: timeout or checksum fail
ocupado  out  1  high in every state except OCIOSO
db_estado  out  4  current state code

Behaviour:
- dht_in passes through a 2-FF synchronizer (lin). Edges are detected on lin versus its previous value.
- Prescaler counts 0..CICLOS_US-1 and emits a tick. The µs counter (15 bits, saturating) advances on each tick. Both counters clear on every state entry.
- State encoding: OCIOSO=0, START_LOW=1, START_SOLTA=2, RESP_LOW=3, RESP_HIGH=4, BIT_LOW=5, BIT_HIGH=6, VERIFICA=7, FIM_OK=8, FIM_ERRO=9. Any other code → OCIOSO.
- OCIOSO: when medir=1, go to START_LOW next cycle. Clear the bit counter and the shift register.
- START_LOW: dht_oe=1 (only state driving the line). When µs count reaches T_START_US, go to START_SOLTA.
- START_SOLTA: dht_oe=0. lin falling → RESP_LOW. µs count reaching T_TIMEOUT_US → FIM_ERRO.
- RESP_LOW: lin rising → RESP_HIGH. Timeout → FIM_ERRO.
- RESP_HIGH: lin falling → BIT_LOW. Timeout → FIM_ERRO.
- BIT_LOW: lin rising → BIT_HIGH. Timeout → FIM_ERRO.
- BIT_HIGH, on lin falling:
  - Shift in (µs count > T_LIMIAR_US), MSB first, into the 40-bit register.
  - Increment the bit counter (6 bits).
  - If the bit just shifted was bit 39, go to VERIFICA; otherwise go to BIT_LOW.
  - Timeout → FIM_ERRO.
- VERIFICA: checksum = (b39..32 + b31..24 + b23..16 + b15..8) mod 256.
  - Equal to b7..0 → FIM_OK.
  - Otherwise → FIM_ERRO.
- FIM_OK: latch the four data bytes into the outputs and assert pronto for exactly this cycle. Go to OCIOSO.
- FIM_ERRO: assert erro for exactly this cycle; output bytes keep their previous values. Go to OCIOSO.
- pronto and erro are never high together.
- medir while ocupado=1 is ignored. It is not queued.
- Latency (nominal frame): medir → pronto ≈ T_START_US + response + 40 bits + 5 cycles.
- Reset values and reset mid-frame: state=OCIOSO, dht_oe=0, pronto=0, erro=0, ocupado=0, all data bytes 0x00, counters and shift register 0. The line is released immediately, asynchronously.
- Synchronizer flops reset to 1 (idle bus high).

Decomposition:
- Shared package/include (tusca_defs): state codes; µs constants T_START_US, T_LIMIAR_US, T_TIMEOUT_US.
- One natural sub-module: tusca_contador_us, the prescaler plus saturating µs counter with synchronous clear and tick output. It can be reused for the control unit's inter-measure delay.

Test Plan:
Simulation runs at CLK_HZ=1000000 (1 cycle/µs) with T_START_US=100.
1. Nominal frame 0x37,0x00,0x19,0x05, checksum 0x55 (bits: 50 µs low, 27 µs/70 µs high) → exactly one pronto pulse; outputs 0x37/0x00/0x19/0x05; dht_oe high for 100 µs only.
2. Same frame with checksum 0x56 → one erro pulse, no pronto; outputs keep the case-1 values.
3. Sensor never responds (line stays high) → erro pulse 200 µs after START_SOLTA entry; ocupado falls the next cycle.
4. Line stuck high at bit 17 → erro when BIT_HIGH µs count reaches 200; the next medir yields a clean case-1 frame.
5. Reset asserted during bit 20 → dht_oe=0 and state OCIOSO within the same cycle; data 0x00; no pronto or erro pulse.
6. Extra medir pulses during a frame → ignored; exactly one pronto; state trace 0→1→2→3→4→(5↔6)→7→8→0.

Source files
------------

// File: rtl/tusca_defs.sv
// rtl/tusca_defs.sv - shared state codes and microsecond constants for the DHT11 reader
package tusca_defs;

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        START_LOW   = 4'd1,
        START_SOLTA = 4'd2,
        RESP_LOW    = 4'd3,
        RESP_HIGH   = 4'd4,
        BIT_LOW     = 4'd5,
        BIT_HIGH    = 4'd6,
        VERIFICA    = 4'd7,
        FIM_OK      = 4'd8,
        FIM_ERRO    = 4'd9
    } estado_t;

    localparam int T_START_US_PADRAO   = 20000;
    localparam int T_LIMIAR_US_PADRAO  = 50;
    localparam int T_TIMEOUT_US_PADRAO = 200;
    localparam int US_W                = 15;

    function automatic logic [7:0] soma_verificacao(input logic [39:0] quadro);
        return quadro[39:32] + quadro[31:24] + quadro[23:16] + quadro[15:8];
    endfunction

endpackage

// File: rtl/tusca_contador_us.sv
// rtl/tusca_contador_us.sv - prescaler plus saturating microsecond counter with synchronous clear
module tusca_contador_us
    import tusca_defs::*;
#(
    parameter int CICLOS_US = 50
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            limpa,
    output logic            tick,
    output logic [US_W-1:0] contagem
);

    localparam int PW = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;

    logic [PW-1:0]   pre;
    logic [PW-1:0]   pre_base;
    logic [US_W-1:0] us;

    // The clear takes effect in the cycle it is asserted, so the first cycle
    // of a new state already reads zero and counts as prescaler position 0.
    assign pre_base = limpa ? '0 : pre;
    assign contagem = limpa ? '0 : us;
    assign tick     = (pre_base == PW'(CICLOS_US - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            us  <= '0;
        end else begin
            pre <= tick ? '0 : pre_base + 1'b1;
            if (tick && contagem != '1)
                us <= contagem + 1'b1;
            else
                us <= contagem;
        end
    end

endmodule

// File: rtl/dht11_medidor.sv
// rtl/dht11_medidor.sv - DHT11 single-wire reader: start pulse, response, 40-bit frame, checksum
module dht11_medidor
    import tusca_defs::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int T_START_US   = T_START_US_PADRAO,
    parameter int T_LIMIAR_US  = T_LIMIAR_US_PADRAO,
    parameter int T_TIMEOUT_US = T_TIMEOUT_US_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic [7:0] umidade_int,
    output logic [7:0] umidade_dec,
    output logic [7:0] temperatura_int,
    output logic [7:0] temperatura_dec,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    localparam int CICLOS_US = CLK_HZ / 1000000;

    estado_t         estado;
    logic            limpa;
    logic [US_W-1:0] us;
    logic [5:0]      nbit;
    logic [39:0]     quadro;
    logic            s1, lin, lin_ant;
    logic            queda, subida, estouro;

    tusca_contador_us #(.CICLOS_US(CICLOS_US)) u_contador (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa),
        .tick     (),
        .contagem (us)
    );

    // Idle bus is pulled high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b1;
            lin     <= 1'b1;
            lin_ant <= 1'b1;
        end else begin
            s1      <= dht_in;
            lin     <= s1;
            lin_ant <= lin;
        end
    end

    assign queda     = lin_ant & ~lin;
    assign subida    = ~lin_ant & lin;
    assign estouro   = (us >= US_W'(T_TIMEOUT_US));
    assign db_estado = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= OCIOSO;
            limpa           <= 1'b0;
            nbit            <= '0;
            quadro          <= '0;
            dht_oe          <= 1'b0;
            ocupado         <= 1'b0;
            pronto          <= 1'b0;
            erro            <= 1'b0;
            umidade_int     <= '0;
            umidade_dec     <= '0;
            temperatura_int <= '0;
            temperatura_dec <= '0;
        end else begin
            limpa  <= 1'b0;
            pronto <= 1'b0;
            erro   <= 1'b0;
            case (estado)
                OCIOSO: begin
                    nbit   <= '0;
                    quadro <= '0;
                    if (medir) begin
                        estado  <= START_LOW;
                        limpa   <= 1'b1;
                        dht_oe  <= 1'b1;
                        ocupado <= 1'b1;
                    end
                end
                START_LOW: if (us >= US_W'(T_START_US)) begin
                    estado <= START_SOLTA;
                    limpa  <= 1'b1;
                    dht_oe <= 1'b0;
                end
                START_SOLTA: if (queda) begin
                    estado <= RESP_LOW;
                    limpa  <= 1'b1;
                end else if (estouro) begin
                    estado <= FIM_ERRO;
                    limpa  <= 1'b1;
                    erro   <= 1'b1;
                end
                RESP_LOW: if (subida) begin
                    estado <= RESP_HIGH;
                    limpa  <= 1'b1;
                end else if (estouro) begin
                    estado <= FIM_ERRO;
                    limpa  <= 1'b1;
                    erro   <= 1'b1;
                end
                RESP_HIGH: if (queda) begin
                    estado <= BIT_LOW;
                    limpa  <= 1'b1;
                end else if (estouro) begin
                    estado <= FIM_ERRO;
                    limpa  <= 1'b1;
                    erro   <= 1'b1;
                end
                BIT_LOW: if (subida) begin
                    estado <= BIT_HIGH;
                    limpa  <= 1'b1;
                end else if (estouro) begin
                    estado <= FIM_ERRO;
                    limpa  <= 1'b1;
                    erro   <= 1'b1;
                end
                // High-time length carries the bit value; the falling edge ends it.
                BIT_HIGH: if (queda) begin
                    quadro <= {quadro[38:0], (us > US_W'(T_LIMIAR_US))};
                    nbit   <= nbit + 6'd1;
                    limpa  <= 1'b1;
                    estado <= (nbit == 6'd39) ? VERIFICA : BIT_LOW;
                end else if (estouro) begin
                    estado <= FIM_ERRO;
                    limpa  <= 1'b1;
                    erro   <= 1'b1;
                end
                VERIFICA: begin
                    limpa <= 1'b1;
                    if (soma_verificacao(quadro) == quadro[7:0]) begin
                        estado          <= FIM_OK;
                        pronto          <= 1'b1;
                        umidade_int     <= quadro[39:32];
                        umidade_dec     <= quadro[31:24];
                        temperatura_int <= quadro[23:16];
                        temperatura_dec <= quadro[15:8];
                    end else begin
                        estado <= FIM_ERRO;
                        erro   <= 1'b1;
                    end
                end
                FIM_OK, FIM_ERRO: begin
                    estado  <= OCIOSO;
                    limpa   <= 1'b1;
                    ocupado <= 1'b0;
                end
                default: begin
                    estado  <= OCIOSO;
                    dht_oe  <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
